// File: rtl/counter_step_decoder_if.sv
// Sample/result bundle between an observed counter tap and its step decoder.
// master drives samples and reads results; slave is the decoder side.
interface counter_step_decoder_if #(
  parameter int CNT_WIDTH = 3,
  parameter int EVT_WIDTH = 8
);
  logic                 clear;
  logic                 valid_in;
  logic [CNT_WIDTH-1:0] count_in;
  logic                 step_valid;
  logic                 step_hold;
  logic                 step_up;
  logic                 step_down;
  logic                 step_load;
  logic                 wrap_det;
  logic [CNT_WIDTH-1:0] load_value;
  logic                 stall;
  logic [EVT_WIDTH-1:0] up_events;
  logic [EVT_WIDTH-1:0] down_events;
  logic [EVT_WIDTH-1:0] load_events;

  modport master (
    output clear, valid_in, count_in,
    input  step_valid, step_hold, step_up, step_down, step_load, wrap_det,
    input  load_value, stall, up_events, down_events, load_events
  );

  modport slave (
    input  clear, valid_in, count_in,
    output step_valid, step_hold, step_up, step_down, step_load, wrap_det,
    output load_value, stall, up_events, down_events, load_events
  );
endinterface

// File: rtl/counter_step_decoder.sv
// Recovers hold/up/down/load commands from the value stream of an up/down/load
// counter, with saturating event counters and a hold-run stall flag.
module counter_step_decoder #(
  parameter int CNT_WIDTH = 3,
  parameter int EVT_WIDTH = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_step_decoder_if.slave  bus
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [EVT_WIDTH-1:0] HOLD_SAT = EVT_WIDTH'(MAX_HOLD);
  localparam logic [EVT_WIDTH-1:0] EVT_MAX  = '1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] prev_q, prev_d;
  logic [CNT_WIDTH-1:0] delta;
  logic [EVT_WIDTH-1:0] hold_run_q, hold_run_d;
  logic                 step_valid_q, step_valid_d;
  logic                 step_hold_q, step_hold_d;
  logic                 step_up_q, step_up_d;
  logic                 step_down_q, step_down_d;
  logic                 step_load_q, step_load_d;
  logic                 wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0] load_value_q, load_value_d;
  logic                 stall_q, stall_d;
  logic [2:0]           evt_inc;
  logic [3*EVT_WIDTH-1:0] evt_flat;

  assign delta = bus.count_in - prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    hold_run_d   = hold_run_q;
    step_valid_d = 1'b0;
    step_hold_d  = 1'b0;
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    step_load_d  = 1'b0;
    wrap_d       = 1'b0;
    load_value_d = load_value_q;
    stall_d      = stall_q;
    evt_inc      = 3'b000;

    if (bus.clear) begin
      // Clear drops tracking so the next sample only re-seeds the reference.
      state_d      = IDLE;
      prev_d       = '0;
      hold_run_d   = '0;
      stall_d      = 1'b0;
      load_value_d = '0;
    end else if (bus.valid_in) begin
      prev_d = bus.count_in;
      case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK: begin
          step_valid_d = 1'b1;
          if (delta == '0) begin
            step_hold_d = 1'b1;
            hold_run_d  = (hold_run_q >= HOLD_SAT) ? HOLD_SAT : hold_run_q + 1'b1;
          end else begin
            hold_run_d = '0;
            // A max->0 transition is a legal up step, so it is never a load.
            if (delta == CNT_ONE) begin
              step_up_d  = 1'b1;
              wrap_d     = (bus.count_in == '0);
              evt_inc[0] = 1'b1;
            end else if (delta == CNT_MAX) begin
              step_down_d = 1'b1;
              wrap_d      = (bus.count_in == CNT_MAX);
              evt_inc[1]  = 1'b1;
            end else begin
              step_load_d  = 1'b1;
              load_value_d = bus.count_in;
              evt_inc[2]   = 1'b1;
            end
          end
          stall_d = (hold_run_d >= HOLD_SAT);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      hold_run_q   <= '0;
      step_valid_q <= 1'b0;
      step_hold_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      step_load_q  <= 1'b0;
      wrap_q       <= 1'b0;
      load_value_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      hold_run_q   <= hold_run_d;
      step_valid_q <= step_valid_d;
      step_hold_q  <= step_hold_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      step_load_q  <= step_load_d;
      wrap_q       <= wrap_d;
      load_value_q <= load_value_d;
      stall_q      <= stall_d;
    end
  end

  // Slots 0/1/2 count up/down/load steps; each sticks at all ones.
  for (genvar gi = 0; gi < 3; gi++) begin : g_evt
    logic [EVT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (bus.clear) begin
        cnt_d = '0;
      end else if (evt_inc[gi] && (cnt_q != EVT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign evt_flat[gi*EVT_WIDTH +: EVT_WIDTH] = cnt_q;
  end

  assign bus.step_valid  = step_valid_q;
  assign bus.step_hold   = step_hold_q;
  assign bus.step_up     = step_up_q;
  assign bus.step_down   = step_down_q;
  assign bus.step_load   = step_load_q;
  assign bus.wrap_det    = wrap_q;
  assign bus.load_value  = load_value_q;
  assign bus.stall       = stall_q;
  assign bus.up_events   = evt_flat[0*EVT_WIDTH +: EVT_WIDTH];
  assign bus.down_events = evt_flat[1*EVT_WIDTH +: EVT_WIDTH];
  assign bus.load_events = evt_flat[2*EVT_WIDTH +: EVT_WIDTH];

endmodule
